// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART transmitter between two byte requesters.
// Optional UART_ARB_STATS_EN adds per-requester byte counters and a lock-timeout counter.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 2170,
  parameter int TO_W         = 12,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [1:0]       grant,
  output logic             timeout_evt
`ifdef UART_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat0_bytes,
  output logic [CNT_W-1:0] stat1_bytes,
  output logic [7:0]       stat_timeouts
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_START, S_SETTLE, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            last_q;
  logic            load;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            accept;
  logic            to_hit;

  assign sel_valid = owner_q ? req1_valid : req0_valid;
  assign sel_data  = owner_q ? req1_data  : req0_data;
  assign sel_last  = owner_q ? req1_last  : req0_last;
  assign accept    = (state_q == S_ARMED) && sel_valid && !tx_busy;
  assign to_hit    = (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1));

  assign req0_ready = (state_q == S_ARMED) && !owner_q && !tx_busy;
  assign req1_ready = (state_q == S_ARMED) &&  owner_q && !tx_busy;
  assign grant      = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    to_cnt_d    = to_cnt_q;
    load        = 1'b0;
    tx_start    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d  = (req0_valid && req1_valid) ? rr_q : req1_valid;
          to_cnt_d = '0;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        // An accept on the terminal-count cycle takes precedence over revocation.
        if (accept) begin
          load     = 1'b1;
          to_cnt_d = '0;
          state_d  = S_START;
        end else if (to_hit) begin
          timeout_evt = 1'b1;
          rr_d        = ~owner_q;
          to_cnt_d    = '0;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_START: begin
        tx_start = 1'b1;
        state_d  = S_SETTLE;
      end
      S_SETTLE: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_d    = ~owner_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      to_cnt_q <= '0;
      tx_data  <= 8'h00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      to_cnt_q <= to_cnt_d;
      if (load) tx_data <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (load) last_q <= sel_last;
  end

`ifdef UART_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat0_bytes   <= '0;
      stat1_bytes   <= '0;
      stat_timeouts <= 8'h00;
    end else begin
      if (accept && !owner_q) stat0_bytes <= stat0_bytes + CNT_W'(1);
      if (accept &&  owner_q) stat1_bytes <= stat1_bytes + CNT_W'(1);
      if (timeout_evt)        stat_timeouts <= stat_timeouts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (grant, byte) pairs are queued per scenario
// and checked whenever the arbiter pulses tx_start.
module tb_uart_tx_arbiter;
  localparam int LT   = 16;
  localparam int BUSY = 30;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, tx_start, tx_busy, timeout_evt;
  logic [7:0] tx_data;
  logic [1:0] grant;
`ifdef UART_ARB_STATS_EN
  logic [15:0] stat0_bytes, stat1_bytes;
  logic [7:0]  stat_timeouts;
  bit          stats_mode = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int nstart = 0;
  int bcnt = 0;

  typedef struct packed {logic [1:0] g; logic [7:0] d;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.LOCK_TIMEOUT(LT), .TO_W(12), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant), .timeout_evt(timeout_evt)
`ifdef UART_ARB_STATS_EN
    , .stat0_bytes(stat0_bytes), .stat1_bytes(stat1_bytes), .stat_timeouts(stat_timeouts)
`endif
  );

  // UART core model: busy rises the cycle after tx_start and holds for BUSY cycles
  always @(posedge clk or negedge resetn) begin
    if (!resetn) bcnt <= 0;
    else if (tx_start) bcnt <= BUSY;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  always @(negedge clk) begin
    exp_t e;
    if (resetn && tx_start) begin
      nstart++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got grant=%b data=%h, required no start", grant, tx_data);
      end else begin
        e = q.pop_front();
        if ({grant, tx_data} !== {e.g, e.d}) begin
          bad++;
          $display("FAIL sb_byte: got grant=%b data=%h, required grant=%b data=%h", grant, tx_data, e.g, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send0(input logic [7:0] d, input logic l);
    int n = 0;
    req0_valid = 1'b1; req0_data = d; req0_last = l;
    @(negedge clk);
    while (!req0_ready && n < 500) begin n++; @(negedge clk); end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL req0_accept: byte %h not accepted within 500 cycles, required accept", d);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    int n = 0;
    req1_valid = 1'b1; req1_data = d; req1_last = l;
    @(negedge clk);
    while (!req1_ready && n < 500) begin n++; @(negedge clk); end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL req1_accept: byte %h not accepted within 500 cycles, required accept", d);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
  endtask

  task automatic apply_reset;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resetn = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain_check(input string name);
    repeat (BUSY + 8) @(negedge clk);
    total++;
    if (q.size() != 0 || grant !== 2'b00) begin
      bad++;
      $display("FAIL %s_end: pending=%0d grant=%b, required pending=0 grant=00", name, q.size(), grant);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_start, req0_ready, req1_ready, timeout_evt, grant, tx_data} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: start=%b r0=%b r1=%b to=%b grant=%b data=%h, required all 0",
               tx_start, req0_ready, req1_ready, timeout_evt, grant, tx_data);
    end
    @(posedge clk); #1 resetn = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (grant !== 2'b00 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: grant=%b start=%b with no requests, required 00/0", grant, tx_start);
    end
  endtask

  task automatic test_single;
    int s0;
    apply_reset;
    q.push_back({2'b01, 8'h34});
    s0 = nstart;
    fork
      send0(8'h34, 1'b1);
      begin
        @(negedge clk);
        total++;
        if (grant !== 2'b00) begin
          bad++; $display("FAIL single_latency0: grant=%b, required 00", grant);
        end
        @(negedge clk);
        total++;
        if (grant !== 2'b01 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
          bad++;
          $display("FAIL single_grant: grant=%b r0=%b r1=%b, required 01/1/0", grant, req0_ready, req1_ready);
        end
      end
    join
    wait_drain_check("single");
    total++;
    if (nstart - s0 != 1) begin
      bad++; $display("FAIL single_pulses: tx_start pulses=%0d, required 1", nstart - s0);
    end
  endtask

  task automatic scen_packet;
    bit done0 = 1'b0;
    int viol = 0;
    q.push_back({2'b01, 8'h34});
    q.push_back({2'b01, 8'h35});
    q.push_back({2'b01, 8'h2A});
    q.push_back({2'b10, 8'h39});
    fork
      begin send0(8'h34, 1'b0); send0(8'h35, 1'b0); send0(8'h2A, 1'b1); done0 = 1'b1; end
      send1(8'h39, 1'b1);
      begin
        while (!done0) begin
          @(negedge clk);
          if (req1_ready) viol++;
        end
      end
    join
    wait_drain_check("packet");
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL packet_lock: req1_ready high %0d cycles during req0 packet, required 0", viol);
    end
  endtask

  task automatic test_packet;
    apply_reset;
    scen_packet;
  endtask

  task automatic test_round_robin;
    apply_reset;
    for (int i = 0; i < 4; i++) begin
      q.push_back({2'b01, 8'h50 + 8'(i)});
      q.push_back({2'b10, 8'h60 + 8'(i)});
    end
    fork
      for (int i = 0; i < 4; i++) send0(8'h50 + 8'(i), 1'b1);
      for (int j = 0; j < 4; j++) send1(8'h60 + 8'(j), 1'b1);
    join
    wait_drain_check("rr");
  endtask

  task automatic scen_timeout;
    int ev_at = -1;
    int nev = 0;
    int k;
    q.push_back({2'b10, 8'h30});
    q.push_back({2'b01, 8'h33});
    fork
      send1(8'h30, 1'b0);
      begin repeat (3) @(posedge clk); #1; send0(8'h33, 1'b1); end
      begin
        k = 0;
        while (!tx_busy && k < 2000) begin @(negedge clk); k++; end
        k = 0;
        while (tx_busy && k < 2000) begin @(negedge clk); k++; end
        for (int n = 1; n <= LT + 1; n++) begin
          @(negedge clk);
          if (timeout_evt) begin nev++; if (ev_at < 0) ev_at = n; end
          if (n == LT + 1) begin
            total++;
            if (grant !== 2'b00) begin
              bad++; $display("FAIL timeout_grant: grant=%b after revoke, required 00", grant);
            end
`ifdef UART_ARB_STATS_EN
            if (stats_mode) begin
              total++;
              if (stat0_bytes !== 16'd3 || stat1_bytes !== 16'd2 || stat_timeouts !== 8'd1) begin
                bad++;
                $display("FAIL stats_at_timeout: s0=%0d s1=%0d to=%0d, required 3/2/1",
                         stat0_bytes, stat1_bytes, stat_timeouts);
              end
            end
`endif
          end
        end
      end
    join
    total++;
    if (ev_at != LT || nev != 1) begin
      bad++; $display("FAIL timeout_evt: first at %0d count %0d, required at %0d count 1", ev_at, nev, LT);
    end
    wait_drain_check("timeout");
  endtask

  task automatic test_timeout;
    apply_reset;
    scen_timeout;
  endtask

  task automatic test_async_reset;
    int k = 0;
    apply_reset;
    q.push_back({2'b01, 8'h2E});
    q.push_back({2'b01, 8'h2F});
    send0(8'h2E, 1'b1);
    while (grant !== 2'b00 && k < 500) begin @(negedge clk); k++; end
    send0(8'h2F, 1'b1);
    k = 0;
    while (!tx_busy && k < 500) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({tx_start, req0_ready, req1_ready, grant, tx_data} !== 13'h0) begin
      bad++;
      $display("FAIL areset_now: start=%b r0=%b r1=%b grant=%b data=%h, required all 0",
               tx_start, req0_ready, req1_ready, grant, tx_data);
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL areset_pending: pending=%0d, required 0", q.size());
    end
    @(negedge clk) resetn = 1'b1;
    q.push_back({2'b01, 8'h40});
    q.push_back({2'b10, 8'h41});
    @(posedge clk); #1;
    fork
      send0(8'h40, 1'b1);
      send1(8'h41, 1'b1);
      begin
        @(negedge clk); @(negedge clk);
        total++;
        if (grant !== 2'b01) begin
          bad++; $display("FAIL areset_rr: grant=%b after reset, required 01", grant);
        end
      end
    join
    wait_drain_check("areset");
  endtask

`ifdef UART_ARB_STATS_EN
  task automatic test_stats;
    apply_reset;
    stats_mode = 1'b1;
    scen_packet;
    scen_timeout;
    stats_mode = 1'b0;
    total++;
    if (stat0_bytes !== 16'd4 || stat1_bytes !== 16'd2 || stat_timeouts !== 8'd1) begin
      bad++;
      $display("FAIL stats_final: s0=%0d s1=%0d to=%0d, required 4/2/1", stat0_bytes, stat1_bytes, stat_timeouts);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_packet;
    test_round_robin;
    test_timeout;
    test_async_reset;
`ifdef UART_ARB_STATS_EN
    test_stats;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
